// File: rtl/emin_seg_dp_if.sv
// emin_seg_dp_if: Emin stream in, DP row results and traceback segments out
// master drives start/row index and the Emin sample stream; slave is the DP stage.
interface emin_seg_dp_if #(
  parameter int BIT_WIDTH = 32,
  parameter int I = 160
);
  localparam int IW = $clog2(I);
  logic start_in;
  logic [IW-1:0] i_in;
  logic emin_valid_in;
  logic [IW-1:0] j_in;
  logic signed [BIT_WIDTH-1:0] emin_in;
  logic ready_out;
  logic row_done_out;
  logic signed [BIT_WIDTH-1:0] cost_out;
  logic [IW-1:0] argmin_out;
  logic seg_valid_out;
  logic [IW-1:0] seg_start_out;
  logic [IW-1:0] seg_end_out;
  logic trace_done_out;
  modport master (
    output start_in, i_in, emin_valid_in, j_in, emin_in,
    input ready_out, row_done_out, cost_out, argmin_out,
    input seg_valid_out, seg_start_out, seg_end_out, trace_done_out
  );
  modport slave (
    input start_in, i_in, emin_valid_in, j_in, emin_in,
    output ready_out, row_done_out, cost_out, argmin_out,
    output seg_valid_out, seg_start_out, seg_end_out, trace_done_out
  );
endinterface

// File: rtl/emin_seg_dp.sv
// emin_seg_dp: segmentation DP over the Emin stream with backpointer traceback
// clk_in: rising-edge clock; rst_in: async active-low reset
// bus.start_in/i_in start a row; bus.emin_valid_in/j_in/emin_in carry Emin(j,i)
// bus.row_done_out/cost_out/argmin_out report D(i), B(i); bus.seg_* stream the traceback
module emin_seg_dp #(
  parameter int BIT_WIDTH = 32,
  parameter int I = 160,
  parameter logic signed [BIT_WIDTH-1:0] SEG_PENALTY = '0
) (
  input logic clk_in,
  input logic rst_in,
  emin_seg_dp_if.slave bus
);
  localparam int IW = $clog2(I);
  localparam int SW = BIT_WIDTH + 2;
  localparam logic signed [BIT_WIDTH-1:0] MAX = {1'b0, {(BIT_WIDTH-1){1'b1}}};
  localparam logic signed [BIT_WIDTH-1:0] MIN = {1'b1, {(BIT_WIDTH-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, ACCUM, COMMIT, TRACE} state_t;
  state_t state;
  logic signed [BIT_WIDTH-1:0] d_mem [I];
  logic [IW-1:0] b_mem [I];
  logic [IW-1:0] i_reg, a_j, best_j, ptr;
  logic a_valid, take;
  logic signed [BIT_WIDTH-1:0] a_emin, a_prev, best, cand;
  logic signed [SW-1:0] sum;
  // Two guard bits hold the exact three-term sum before clamping
  always_comb begin
    take = state == ACCUM && bus.emin_valid_in && bus.j_in <= i_reg;
    sum = SW'(a_prev) + SW'(a_emin) + SW'(SEG_PENALTY);
    cand = sum > SW'(MAX) ? MAX : sum < SW'(MIN) ? MIN : sum[BIT_WIDTH-1:0];
  end
  assign bus.ready_out = state == IDLE;
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state <= IDLE;
      i_reg <= '0;
      a_valid <= 1'b0;
      a_j <= '0;
      a_emin <= '0;
      a_prev <= '0;
      best <= '0;
      best_j <= '0;
      ptr <= '0;
      bus.row_done_out <= 1'b0;
      bus.cost_out <= '0;
      bus.argmin_out <= '0;
      bus.seg_valid_out <= 1'b0;
      bus.seg_start_out <= '0;
      bus.seg_end_out <= '0;
      bus.trace_done_out <= 1'b0;
      for (int k = 0; k < I; k++) begin
        d_mem[k] <= '0;
        b_mem[k] <= '0;
      end
    end else begin
      bus.row_done_out <= 1'b0;
      bus.seg_valid_out <= 1'b0;
      bus.trace_done_out <= 1'b0;
      a_valid <= take;
      if (take) begin
        a_j <= bus.j_in;
        a_emin <= bus.emin_in;
        a_prev <= bus.j_in == '0 ? '0 : d_mem[bus.j_in - IW'(1)];
      end
      case (state)
        IDLE: if (bus.start_in) begin
          i_reg <= bus.i_in;
          best <= MAX;
          best_j <= '0;
          state <= ACCUM;
        end
        ACCUM: if (a_valid) begin
          if (cand < best) begin
            best <= cand;
            best_j <= a_j;
          end
          if (a_j == i_reg) state <= COMMIT;
        end
        COMMIT: begin
          d_mem[i_reg] <= best;
          b_mem[i_reg] <= best_j;
          bus.row_done_out <= 1'b1;
          bus.cost_out <= best;
          bus.argmin_out <= best_j;
          ptr <= IW'(I - 1);
          state <= i_reg == IW'(I - 1) ? TRACE : IDLE;
        end
        TRACE: begin
          bus.seg_valid_out <= 1'b1;
          bus.seg_start_out <= b_mem[ptr];
          bus.seg_end_out <= ptr;
          // A segment starting at frame 0 is the earliest one, so the walk ends here
          if (b_mem[ptr] == '0) begin
            bus.trace_done_out <= 1'b1;
            state <= IDLE;
          end else ptr <= b_mem[ptr] - IW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_emin_seg_dp.sv
// tb_emin_seg_dp: randomized and directed checks of emin_seg_dp against a DP reference model
module tb_emin_seg_dp;
  localparam int BW = 32;
  localparam int N = 4;
  localparam int IW = $clog2(N);
  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;
  localparam longint PEN = 0;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_checks = 0;
  int n_fail = 0;
  longint d_m [N];
  int b_m [N];
  longint ev [N];
  int gs[$], ge[$], gd[$], xs[$], xe[$];
  always #5 clk = ~clk;
  emin_seg_dp_if #(.BIT_WIDTH(BW), .I(N)) bus();
  emin_seg_dp #(.BIT_WIDTH(BW), .I(N), .SEG_PENALTY(32'sd0)) dut (
    .clk_in(clk),
    .rst_in(rst_n),
    .bus(bus)
  );
  function automatic longint sat(input longint v);
    return v > MAXV ? MAXV : v < MINV ? MINV : v;
  endfunction
  task automatic model_clear();
    for (int k = 0; k < N; k++) begin
      d_m[k] = 0;
      b_m[k] = 0;
    end
  endtask
  task automatic model_row(input int i, output longint c, output int a);
    c = MAXV;
    a = 0;
    for (int j = 0; j <= i; j++) begin
      longint cnd;
      cnd = sat((j == 0 ? 64'sd0 : d_m[j-1]) + ev[j] + PEN);
      if (cnd < c) begin
        c = cnd;
        a = j;
      end
    end
    d_m[i] = c;
    b_m[i] = a;
  endtask
  task automatic exp_trace();
    int p;
    xs.delete();
    xe.delete();
    p = N - 1;
    for (int k = 0; k < N; k++) begin
      xs.push_back(b_m[p]);
      xe.push_back(p);
      if (b_m[p] == 0) break;
      p = b_m[p] - 1;
    end
  endtask
  task automatic send_row(input int i, input int gap, input bit rnd, input bit bad, input bit busy,
                          output int lat, output logic signed [BW-1:0] oc, output logic [IW-1:0] oa);
    @(negedge clk);
    bus.start_in = 1'b1;
    bus.i_in = IW'(i);
    @(negedge clk);
    bus.start_in = 1'b0;
    for (int j = 0; j <= i; j++) begin
      bus.emin_valid_in = 1'b0;
      repeat (rnd ? int'($urandom_range(0, gap)) : gap) @(negedge clk);
      if (bad && j == i && i < N - 1) begin
        bus.emin_valid_in = 1'b1;
        bus.j_in = IW'(i + 1);
        bus.emin_in = -32'sd1000;
        @(negedge clk);
      end
      bus.emin_valid_in = 1'b1;
      bus.j_in = IW'(j);
      bus.emin_in = BW'(ev[j]);
      if (busy && j == 1) begin
        bus.start_in = 1'b1;
        bus.i_in = '0;
      end
      if (j < i) begin
        @(negedge clk);
        bus.start_in = 1'b0;
      end
    end
    lat = -1;
    oc = '0;
    oa = '0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) begin
        bus.emin_valid_in = 1'b0;
        bus.start_in = 1'b0;
      end
      if (bus.row_done_out) begin
        lat = k;
        oc = bus.cost_out;
        oa = bus.argmin_out;
        break;
      end
    end
  endtask
  task automatic grab_trace();
    gs.delete();
    ge.delete();
    gd.delete();
    for (int k = 0; k < 3 * N; k++) begin
      @(negedge clk);
      if (bus.seg_valid_out) begin
        gs.push_back(int'(bus.seg_start_out));
        ge.push_back(int'(bus.seg_end_out));
        gd.push_back(int'(bus.trace_done_out));
      end
      if (bus.trace_done_out) break;
    end
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus.ready_out !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: got %b want 1", bus.ready_out);
    end
    n_checks++;
    if ({bus.row_done_out, bus.seg_valid_out, bus.trace_done_out} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_pulses: got %b want 000", {bus.row_done_out, bus.seg_valid_out, bus.trace_done_out});
    end
    n_checks++;
    if ({bus.cost_out, bus.argmin_out, bus.seg_start_out, bus.seg_end_out} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: cost %0d arg %0d seg %0d..%0d want all 0",
               bus.cost_out, bus.argmin_out, bus.seg_start_out, bus.seg_end_out);
    end
    rst_n = 1'b1;
    model_clear();
  endtask
  task automatic test_directed();
    longint exp_c [N] = '{10, 15, 30, 31};
    int exp_a [N] = '{0, 1, 0, 3};
    longint mc;
    int ma, lat;
    logic signed [BW-1:0] oc;
    logic [IW-1:0] oa;
    for (int i = 0; i < N; i++) begin
      case (i)
        0: ev = '{10, 0, 0, 0};
        1: ev = '{25, 5, 0, 0};
        2: ev = '{30, 20, 15, 0};
        default: ev = '{1000, 1000, 1000, 1};
      endcase
      model_row(i, mc, ma);
      send_row(i, 0, 1'b0, 1'b0, 1'b0, lat, oc, oa);
      n_checks += 3;
      if (longint'(oc) != exp_c[i]) begin
        n_fail++;
        $display("FAIL dir_cost row %0d: got %0d want %0d", i, oc, exp_c[i]);
      end
      if (int'(oa) != exp_a[i]) begin
        n_fail++;
        $display("FAIL dir_argmin row %0d: got %0d want %0d", i, oa, exp_a[i]);
      end
      if (lat != 3) begin
        n_fail++;
        $display("FAIL dir_latency row %0d: got %0d want 3", i, lat);
      end
    end
    grab_trace();
    n_checks++;
    if (gs.size() != 2) begin
      n_fail++;
      $display("FAIL dir_trace_count: got %0d want 2", gs.size());
    end
    if (gs.size() == 2) begin
      n_checks++;
      if (gs[0] != 3 || ge[0] != 3 || gd[0] != 0 || gs[1] != 0 || ge[1] != 2 || gd[1] != 1) begin
        n_fail++;
        $display("FAIL dir_trace_segs: got (%0d,%0d,%0d)(%0d,%0d,%0d) want (3,3,0)(0,2,1)",
                 gs[0], ge[0], gd[0], gs[1], ge[1], gd[1]);
      end
    end
    @(negedge clk);
    n_checks++;
    if (bus.ready_out !== 1'b1 || bus.seg_valid_out !== 1'b0) begin
      n_fail++;
      $display("FAIL dir_post_trace: ready %b seg_valid %b want 1 0", bus.ready_out, bus.seg_valid_out);
    end
  endtask
  task automatic test_saturation();
    longint mc;
    int ma, lat;
    logic signed [BW-1:0] oc;
    logic [IW-1:0] oa;
    for (int i = 0; i < N; i++) begin
      case (i)
        0: ev = '{MAXV - 5, 0, 0, 0};
        1: ev = '{MAXV, 100, 0, 0};
        2: ev = '{MINV, MINV, MINV, 0};
        default: ev = '{-5, MINV, MINV, MINV};
      endcase
      model_row(i, mc, ma);
      send_row(i, 0, 1'b0, 1'b0, 1'b0, lat, oc, oa);
      n_checks += 2;
      if (longint'(oc) != mc || int'(oa) != ma) begin
        n_fail++;
        $display("FAIL sat_row %0d: got cost %0d arg %0d want cost %0d arg %0d", i, oc, oa, mc, ma);
      end
      if (i == 1 && longint'(oc) != MAXV) begin
        n_fail++;
        $display("FAIL sat_clamp_max: got %0d want %0d", oc, MAXV);
      end
      if (i == 3 && longint'(oc) != MINV) begin
        n_fail++;
        $display("FAIL sat_clamp_min: got %0d want %0d", oc, MINV);
      end
    end
    grab_trace();
  endtask
  task automatic test_gaps();
    longint mc;
    int ma, lat;
    logic signed [BW-1:0] oc;
    logic [IW-1:0] oa;
    for (int r = 0; r < 4; r++) begin
      int i;
      i = r < 3 ? r : 2;
      case (i)
        0: ev = '{10, 0, 0, 0};
        1: ev = '{25, 5, 0, 0};
        default: ev = '{7, 3, 40, 0};
      endcase
      model_row(i, mc, ma);
      send_row(i, r == 3 ? 3 : 0, 1'b0, r == 3, 1'b0, lat, oc, oa);
      if (i == 2) begin
        n_checks += 2;
        if (longint'(oc) != 7 || oa !== 2'd0) begin
          n_fail++;
          $display("FAIL gap_row pass %0d: got cost %0d arg %0d want cost 7 arg 0", r, oc, oa);
        end
        if (lat != 3) begin
          n_fail++;
          $display("FAIL gap_latency pass %0d: got %0d want 3", r, lat);
        end
      end
    end
  endtask
  task automatic test_reset_mid();
    longint mc;
    int ma, lat;
    logic signed [BW-1:0] oc;
    logic [IW-1:0] oa;
    ev = '{10, 0, 0, 0};
    model_row(0, mc, ma);
    send_row(0, 0, 1'b0, 1'b0, 1'b0, lat, oc, oa);
    @(negedge clk);
    bus.start_in = 1'b1;
    bus.i_in = 2'd1;
    @(negedge clk);
    bus.start_in = 1'b0;
    bus.emin_valid_in = 1'b1;
    bus.j_in = '0;
    bus.emin_in = 32'sd50;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks += 2;
    if (bus.ready_out !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_ready: got %b want 1", bus.ready_out);
    end
    if (bus.row_done_out !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_row_done: got %b want 0", bus.row_done_out);
    end
    bus.emin_valid_in = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    ev = '{50, 5, 0, 0};
    model_row(1, mc, ma);
    send_row(1, 0, 1'b0, 1'b0, 1'b0, lat, oc, oa);
    n_checks++;
    if (longint'(oc) != 5 || oa !== 2'd1) begin
      n_fail++;
      $display("FAIL midrst_d_cleared: got cost %0d arg %0d want cost 5 arg 1", oc, oa);
    end
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: ev = '{10, 0, 0, 0};
        1: ev = '{25, 5, 0, 0};
        default: ev = '{30, 20, 15, 0};
      endcase
      model_row(i, mc, ma);
      send_row(i, 0, 1'b0, 1'b0, i == 2, lat, oc, oa);
    end
    n_checks++;
    if (longint'(oc) != mc || int'(oa) != ma || lat != 3) begin
      n_fail++;
      $display("FAIL busy_start_ignored: got cost %0d arg %0d lat %0d want cost %0d arg %0d lat 3",
               oc, oa, lat, mc, ma);
    end
  endtask
  function automatic longint rnd_val();
    case ($urandom_range(0, 7))
      0: return MAXV;
      1: return MINV;
      2: return MAXV - longint'($urandom_range(0, 50));
      3: return MINV + longint'($urandom_range(0, 50));
      default: return longint'($urandom_range(0, 2000)) - 1000;
    endcase
  endfunction
  task automatic test_random();
    longint mc;
    int ma, lat;
    logic signed [BW-1:0] oc;
    logic [IW-1:0] oa;
    for (int it = 0; it < 12; it++) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) ev[j] = rnd_val();
        model_row(i, mc, ma);
        send_row(i, 2, 1'b1, $urandom_range(0, 1) == 1, 1'b0, lat, oc, oa);
        n_checks++;
        if (longint'(oc) != mc || int'(oa) != ma || lat != 3) begin
          n_fail++;
          $display("FAIL rnd_row it %0d row %0d: got cost %0d arg %0d lat %0d want cost %0d arg %0d lat 3",
                   it, i, oc, oa, lat, mc, ma);
        end
      end
      exp_trace();
      grab_trace();
      n_checks++;
      if (gs.size() != xs.size()) begin
        n_fail++;
        $display("FAIL rnd_trace_count it %0d: got %0d want %0d", it, gs.size(), xs.size());
      end
      for (int k = 0; k < xs.size() && k < gs.size(); k++) begin
        n_checks++;
        if (gs[k] != xs[k] || ge[k] != xe[k] || gd[k] != int'(k == xs.size() - 1)) begin
          n_fail++;
          $display("FAIL rnd_trace_seg it %0d #%0d: got (%0d,%0d,done %0d) want (%0d,%0d,done %0d)",
                   it, k, gs[k], ge[k], gd[k], xs[k], xe[k], int'(k == xs.size() - 1));
        end
      end
    end
  endtask
  initial begin
    bus.start_in = 1'b0;
    bus.i_in = '0;
    bus.emin_valid_in = 1'b0;
    bus.j_in = '0;
    bus.emin_in = '0;
    test_reset();
    test_directed();
    test_saturation();
    test_gaps();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
